mux_4_reg: RTL and testbench

- Four-input, WIDTH-bit data selector with a registered output, used in the microprocessor datapath.
- It picks one of four operand/register buses (r1..r4) under a 2-bit select formed from s1 and s0.
- The chosen word is presented on out one clock after the select and data are sampled.
- A parameter bypasses the register, giving a purely combinational mux.

---
 rtl/mux_4_reg.sv | 44 ++++
 tb/tb_mux_4_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_reg.sv
// Four-input WIDTH-bit selector for the datapath, with an optional output register.
// OUT_REG=1 gives one cycle of latency and an async active-low clear; OUT_REG=0 is purely combinational.
module mux_4_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic [WIDTH-1:0] r4,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] sel_word;

  assign sel = {s1, s0};

  // An unknown select propagates X in simulation rather than favouring any input.
  always_comb begin
    sel_word = 'x;
    case (sel)
      2'b00:   sel_word = r1;
      2'b01:   sel_word = r2;
      2'b10:   sel_word = r3;
      2'b11:   sel_word = r4;
      default: sel_word = 'x;
    endcase
  end

  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= sel_word;
    end
  end else begin : g_comb
    assign out = sel_word;
  end

endmodule

// File: tb/tb_mux_4_reg.sv
// Scoreboard bench for mux_4_reg: registered build checked edge by edge, combinational build checked with no clock.
module tb_mux_4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_c = 1'b0;
  logic       rst_c = 1'b1;
  logic [7:0] r1, r2, r3, r4;
  logic       s0, s1;
  logic [7:0] out, out_c;

  logic [7:0] sb[$];
  logic [7:0] exp_v;
  logic [7:0] prev;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mux_4_reg #(.WIDTH(8), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .s0(s0), .s1(s1), .out(out)
  );

  mux_4_reg #(.WIDTH(8), .OUT_REG(1'b0)) dut_c (
    .clk(clk_c), .rst_n(rst_c), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .s0(s0), .s1(s1), .out(out_c)
  );

  function automatic logic [7:0] model(input logic [1:0] sel,
                                       input logic [7:0] a, b, c, d);
    logic [7:0] t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    return t[sel];
  endfunction

  function automatic logic [7:0] cur_model();
    return model({s1, s0}, r1, r2, r3, r4);
  endfunction

  task automatic pop_check(input string name);
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, out=%02h", name, out);
    end else begin
      exp_v = sb.pop_front();
      if (out !== exp_v) begin
        bad++;
        $display("FAIL %s: out=%02h expected=%02h", name, out, exp_v);
      end
      prev = exp_v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r1 = 8'h00; r2 = 8'hAA; r3 = 8'hFF; r4 = 8'h55;
    {s1, s0} = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: out=%02h expected=00", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(cur_model());
    pop_check("reset_release");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: out=%02h expected=00", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(cur_model());
    pop_check("reset_rerelease");
  endtask

  task automatic test_sweep();
    logic [1:0] codes[4];
    codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11; codes[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {s1, s0} = codes[i];
      sb.push_back(cur_model());
      #1;
      total++;
      if (out !== prev) begin
        bad++;
        $display("FAIL sweep_hold[%0d]: out=%02h expected=%02h", i, out, prev);
      end
      pop_check("sweep");
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    r2 = 8'h3C;
    #1;
    total++;
    if (out !== 8'hAA) begin
      bad++;
      $display("FAIL latency_hold: out=%02h expected=aa", out);
    end
    sb.push_back(cur_model());
    pop_check("latency_capture");
    @(negedge clk);
    r1 = 8'h11; r3 = 8'h22; r4 = 8'h33;
    sb.push_back(8'h3C);
    pop_check("unselected_inputs");
    @(negedge clk);
    r1 = 8'h00; r2 = 8'hAA; r3 = 8'hFF; r4 = 8'h55;
    {s1, s0} = 2'b00;
    sb.push_back(cur_model());
    pop_check("restore_sel00");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    {s1, s0} = 2'b11;
    r4 = 8'h81;
    sb.push_back(cur_model());
    #1;
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL simul_hold: out=%02h expected=00", out);
    end
    pop_check("simul_capture");
    #3;
    total++;
    if (out !== 8'h81) begin
      bad++;
      $display("FAIL simul_stable: out=%02h expected=81", out);
    end
    @(negedge clk);
    r4 = 8'h55;
    {s1, s0} = 2'b10;
    sb.push_back(cur_model());
    pop_check("sel10");
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL midreset_async: out=%02h expected=00", out);
    end
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL midreset_hold: out=%02h expected=00", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(8'hFF);
    pop_check("midreset_release");
  endtask

  task automatic test_comb();
    logic [7:0] want[4];
    want[0] = 8'h00; want[1] = 8'hAA; want[2] = 8'hFF; want[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      {s1, s0} = 2'(i);
      #1;
      total++;
      if (out_c !== want[i]) begin
        bad++;
        $display("FAIL comb_sel[%0d]: out=%02h expected=%02h", i, out_c, want[i]);
      end
    end
    rst_c = 1'b0;
    {s1, s0} = 2'b10;
    #1;
    total++;
    if (out_c !== 8'hFF) begin
      bad++;
      $display("FAIL comb_rst_ignored: out=%02h expected=ff", out_c);
    end
    r3 = 8'h5A;
    #1;
    total++;
    if (out_c !== 8'h5A) begin
      bad++;
      $display("FAIL comb_data_follow: out=%02h expected=5a", out_c);
    end
    rst_c = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev = 8'h00;
    test_reset();
    test_sweep();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_comb();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
